// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end of the single-port RAM.
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// Load/shift register that puts one RAM read byte on MISO, MSB first.
module spi_tx_serializer
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 miso_o,
    output logic                 done_o
);

    localparam int CW = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 miso_q, miso_d;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        miso_d = miso_q;
        if (clear_i) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            miso_d = 1'b0;
        end else if (load_i) begin
            // Bit 7 goes straight out on the load edge; the rest queue behind it.
            miso_d = data_i[DATA_BITS-1];
            sh_d   = {data_i[DATA_BITS-2:0], 1'b0};
            cnt_d  = CW'(DATA_BITS - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                miso_d = sh_q[DATA_BITS-1];
                sh_d   = {sh_q[DATA_BITS-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
            end else begin
                miso_d = 1'b0;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;
    assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: deserialises MOSI frames into RAM command words and returns read bytes on MISO.
//   state     | meaning
//   IDLE      | SS_n high, waiting for a frame
//   CHK_CMD   | sampling the direction bit
//   WRITE     | shifting a write-address/write-data payload
//   READ_ADD  | shifting a read-address payload
//   READ_DATA | shifting a read-data payload, then waiting for and sending the RAM byte
module spi_slave_ctrl
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_BITS-1:0]  tx_data,
    input  logic                  tx_valid
);

    spi_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rd_addr_rcvd_q, rd_addr_rcvd_d;
    logic                  tx_load;
    logic                  tx_done;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_rcvd_d = rd_addr_rcvd_q;
        tx_load        = 1'b0;
        if (SS_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    cnt_d = '0;
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_rcvd_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt_q < 4'(FRAME_BITS)) begin
                        rx_data_d = {rx_data_q[FRAME_BITS-2:0], MOSI};
                        cnt_d     = cnt_q + 4'd1;
                        if (cnt_q == 4'(FRAME_BITS - 1)) begin
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) rd_addr_rcvd_d = 1'b1;
                        end
                    end else if (state_q == READ_DATA && cnt_q == 4'(FRAME_BITS) && tx_valid) begin
                        // Counter steps past the frame length so the byte is taken only once.
                        tx_load = 1'b1;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (tx_done) rd_addr_rcvd_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_rcvd_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_rcvd_q <= rd_addr_rcvd_d;
        end
    end

    spi_tx_serializer u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (SS_n),
        .load_i  (tx_load),
        .data_i  (tx_data),
        .miso_o  (MISO),
        .done_o  (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: write, read-address/read-data, abort, reset and no-response cases.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_cmp = 0;
    int n_err = 0;

    spi_slave_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives SS_n low, the direction bit and nbits payload bits; rx_valid must rise only after bit 0.
    task automatic frame(input logic dir, input logic [9:0] pl, input int nbits);
        SS_n = 1'b0;
        step();
        MOSI = dir;
        step();
        chk_bit("rx_valid_dir", rx_valid, 1'b0);
        for (int k = 0; k < nbits; k++) begin
            MOSI = pl[9-k];
            step();
            chk_bit("rx_valid_bit", rx_valid, (k == 9));
            chk_bit("miso_during_rx", MISO, 1'b0);
        end
        if (nbits == 10) chk_word("rx_data", rx_data, pl);
        MOSI = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
        chk_bit("rx_valid_idle", rx_valid, 1'b0);
    endtask

    // RAM answers one cycle after rx_valid; expects the byte on MISO MSB first, then 0.
    task automatic rd_byte(input logic [7:0] d);
        step();
        chk_bit("rx_valid_pulse_end", rx_valid, 1'b0);
        chk_bit("miso_wait", MISO, 1'b0);
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
        chk_bit("miso_b7", MISO, d[7]);
        for (int b = 6; b >= 0; b--) begin
            step();
            chk_bit("miso_bit", MISO, d[b]);
        end
        step();
        chk_bit("miso_after", MISO, 1'b0);
        step();
        chk_bit("miso_hold", MISO, 1'b0);
    endtask

    // RAM offers a byte that must be ignored; MISO stays 0 for n cycles.
    task automatic no_tx(input logic [7:0] d, input int n);
        step();
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk_bit("miso_quiet", MISO, 1'b0);
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        step();
        step();
        chk_bit("rst_miso", MISO, 1'b0);
        chk_bit("rst_rx_valid", rx_valid, 1'b0);
        chk_word("rst_rx_data", rx_data, 10'h000);
        rst_n = 1'b1;
        step();

        // Write-address and write-data frames
        frame(1'b0, {OP_WR_ADDR, 8'hA5}, 10);
        step();
        chk_bit("wr_rx_valid_once", rx_valid, 1'b0);
        chk_bit("wr_miso", MISO, 1'b0);
        end_frame();
        frame(1'b0, {OP_WR_DATA, 8'h3C}, 10);
        end_frame();

        // Read address, then read data returning 0xC3
        frame(1'b1, {OP_RD_ADDR, 8'hA5}, 10);
        no_tx(8'hFF, 4);
        end_frame();
        frame(1'b1, {OP_RD_DATA, 8'h00}, 10);
        rd_byte(8'hC3);
        end_frame();

        // rd_addr_rcvd cleared: next read frame is a read address (RAM byte ignored)
        frame(1'b1, {OP_RD_ADDR, 8'h11}, 10);
        no_tx(8'hFF, 10);
        end_frame();

        // Abort after 5 payload bits: no rx_valid, rd_addr_rcvd still set
        frame(1'b1, {OP_RD_DATA, 8'h55}, 5);
        end_frame();
        chk_bit("abort_no_valid", rx_valid, 1'b0);

        // Still routed to READ_DATA; reset while MISO carries bit 3 of 0x3C
        frame(1'b1, 10'h3FF, 10);
        step();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        step();
        tx_valid = 1'b0;
        chk_bit("rst_seq_b7", MISO, 1'b0);
        step();
        chk_bit("rst_seq_b6", MISO, 1'b0);
        step();
        chk_bit("rst_seq_b5", MISO, 1'b1);
        step();
        chk_bit("rst_seq_b4", MISO, 1'b1);
        step();
        chk_bit("rst_seq_b3", MISO, 1'b1);
        rst_n = 1'b0;
        step();
        chk_bit("midrst_miso", MISO, 1'b0);
        chk_bit("midrst_rx_valid", rx_valid, 1'b0);
        chk_word("midrst_rx_data", rx_data, 10'h000);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        step();

        // After reset, a read frame is a read address
        frame(1'b1, {OP_RD_ADDR, 8'hA5}, 10);
        no_tx(8'hFF, 10);
        end_frame();

        // Second read-address frame goes to READ_DATA, opcode forwarded as sent
        frame(1'b1, {OP_RD_ADDR, 8'h5A}, 10);
        chk_word("fwd_opcode", {8'h00, rx_data[9:8]}, {8'h00, OP_RD_ADDR});
        rd_byte(8'h81);
        end_frame();

        // No tx_valid in READ_DATA: MISO stays 0, recovery on SS_n high
        frame(1'b1, {OP_RD_ADDR, 8'h01}, 10);
        end_frame();
        frame(1'b1, {OP_RD_DATA, 8'h00}, 10);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_bit("no_resp_miso", MISO, 1'b0);
        end
        end_frame();
        frame(1'b1, {OP_RD_DATA, 8'h02}, 10);
        rd_byte(8'h6D);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
